// File: rtl/inimigos_pkg.sv
// Shared types and defaults for the enemy-alive bitmap producer.
package inimigos_pkg;

  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StBusca  = 2'd1,
    StParado = 2'd2
  } state_e;

  // Right-shifting Galois form of x^16+x^14+x^13+x^11+1.
  localparam logic [15:0] LfsrTaps        = 16'hB400;
  localparam logic [15:0] LfsrSeedDefault = 16'hACE1;

  localparam int unsigned NInimigosDefault = 16;
  localparam int unsigned IdxWDefault      = 4;

endpackage

// File: rtl/inimigos_lfsr16.sv
// Free-running 16-bit Galois LFSR; advances every cycle, reloads the seed on reset.
module lfsr16
  import inimigos_pkg::*;
(
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [15:0] seed_i,
  output logic [15:0] state_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) begin
      lfsr_d = lfsr_d ^ LfsrTaps;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      lfsr_q <= seed_i;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/inimigos_controle.sv
// Enemy-alive bitmap: periodic spawn into free slots (random start), hit handshake, kill strobe.
module inimigos_controle
  import inimigos_pkg::*;
#(
  parameter int unsigned N_INIMIGOS   = NInimigosDefault,
  parameter int unsigned IDX_W        = IdxWDefault,
  parameter int unsigned SPAWN_PERIOD = 50000000,
  parameter logic [15:0] LFSR_SEED    = LfsrSeedDefault
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  reiniciarJogo,
  input  logic                  perdeuJogo,
  input  logic                  hit_valid,
  input  logic [IDX_W-1:0]      hit_idx,
  output logic                  hit_ready,
  output logic [N_INIMIGOS-1:0] inimigosvida,
  output logic                  kill_pulse,
  output logic [IDX_W-1:0]      kill_idx,
  output logic [IDX_W:0]        vivos,
  output logic                  cheio
);

  localparam int unsigned      TmrW    = $clog2(SPAWN_PERIOD);
  localparam logic [TmrW-1:0]  TmrLast = TmrW'(SPAWN_PERIOD - 1);
  localparam logic [IDX_W:0]   NFull   = (IDX_W + 1)'(N_INIMIGOS);

  state_e                state_q, state_d;
  logic [TmrW-1:0]       timer_q, timer_d;
  logic [N_INIMIGOS-1:0] vida_q, vida_d;
  logic [IDX_W:0]        vivos_q, vivos_d;
  logic                  cheio_q, cheio_d;
  logic                  kill_pulse_q, kill_pulse_d;
  logic [IDX_W-1:0]      kill_idx_q, kill_idx_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [IDX_W-1:0]      probes_q, probes_d;

  logic [15:0] lfsr_state;
  logic        unused_lfsr;
  logic        hit_fire, kill, spawn, tmr_last;

  lfsr16 u_lfsr (
    .CLOCK_50 (CLOCK_50),
    .reset    (reset),
    .seed_i   (LFSR_SEED),
    .state_o  (lfsr_state)
  );

  assign unused_lfsr = ^lfsr_state[15:IDX_W];

  assign hit_ready = (state_q != StParado) && !reset;
  assign hit_fire  = hit_valid && hit_ready;
  assign kill      = hit_fire && vida_q[hit_idx];
  assign tmr_last  = (timer_q == TmrLast);

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    vida_d       = vida_q;
    vivos_d      = vivos_q;
    kill_pulse_d = 1'b0;
    kill_idx_d   = kill_idx_q;
    ptr_d        = ptr_q;
    probes_d     = probes_q;
    spawn        = 1'b0;

    if (reiniciarJogo) begin
      vida_d  = '0;
      vivos_d = '0;
      timer_d = '0;
      state_d = StRun;
    end else if (state_q == StParado) begin
      state_d = StParado;
    end else if (perdeuJogo) begin
      state_d = StParado;
    end else begin
      timer_d = tmr_last ? '0 : timer_q + 1'b1;
      if (kill) begin
        vida_d[hit_idx] = 1'b0;
        kill_pulse_d    = 1'b1;
        kill_idx_d      = hit_idx;
      end
      unique case (state_q)
        StRun: begin
          if (tmr_last && !cheio_q) begin
            state_d  = StBusca;
            ptr_d    = lfsr_state[IDX_W-1:0];
            probes_d = '0;
          end
        end
        StBusca: begin
          // A slot being hit this cycle counts as occupied, so spawn never lands on a kill.
          if (!vida_q[ptr_q] && !(hit_fire && (hit_idx == ptr_q))) begin
            vida_d[ptr_q] = 1'b1;
            spawn         = 1'b1;
            state_d       = StRun;
          end else begin
            ptr_d    = ptr_q + 1'b1;
            probes_d = probes_q + 1'b1;
            if (&probes_q) begin
              state_d = StRun;
            end
          end
        end
        default: ;
      endcase
      if (spawn && !kill) begin
        vivos_d = vivos_q + 1'b1;
      end else if (!spawn && kill) begin
        vivos_d = vivos_q - 1'b1;
      end
    end

    cheio_d = (vivos_d == NFull);
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q      <= StRun;
      timer_q      <= '0;
      vida_q       <= '0;
      vivos_q      <= '0;
      cheio_q      <= 1'b0;
      kill_pulse_q <= 1'b0;
      kill_idx_q   <= '0;
      ptr_q        <= '0;
      probes_q     <= '0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      vida_q       <= vida_d;
      vivos_q      <= vivos_d;
      cheio_q      <= cheio_d;
      kill_pulse_q <= kill_pulse_d;
      kill_idx_q   <= kill_idx_d;
      ptr_q        <= ptr_d;
      probes_q     <= probes_d;
    end
  end

  assign inimigosvida = vida_q;
  assign kill_pulse   = kill_pulse_q;
  assign kill_idx     = kill_idx_q;
  assign vivos        = vivos_q;
  assign cheio        = cheio_q;

endmodule
